// File: rtl/ling_sum_stage.sv
// Ling adder output stage: turns (p, g, h, cin) into sum/cout/ovf.
// The result is registered behind a 2-entry skid buffer so that in_ready
// comes straight from state and never from out_ready.
//
// state | meaning
// EMPTY | main register M invalid, nothing buffered
// ONE   | M valid (drives out_*), skid register S invalid
// FULL  | M and S both valid, upstream stalled

module ling_sum_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_g,
  input  logic [WIDTH-1:0] in_h,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] t, c, sum_c;
  logic             cout_c, ovf_c;
  logic [WIDTH+1:0] res_c, m_data, s_data;
  logic             in_xfer, out_xfer;
  logic             load_m, load_s, move_s;

  // True carries from the Ling pseudo-carries: c[i] = t[i-1] & h[i],
  // where h[i] arrives on in_h[i-1].
  always_comb begin
    t = in_p | in_g;
    c = '0;
    c[0] = in_cin;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = t[i-1] & in_h[i-1];
    end
    sum_c  = in_p ^ c;
    cout_c = t[WIDTH-1] & in_h[WIDTH-1];
    ovf_c  = c[WIDTH-1] ^ cout_c;
    res_c  = {ovf_c, cout_c, sum_c};
  end

  // in_ready depends only on whether S is occupied, which is pure state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next-state and register load controls.
  always_comb begin
    state_next = state;
    load_m     = 1'b0;
    load_s     = 1'b0;
    move_s     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          load_m     = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_m = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end else if (in_xfer) begin
          load_s     = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          move_s     = 1'b1;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Result storage: M feeds the outputs, S holds the overflow entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
      s_data <= '0;
    end else begin
      if (load_m)      m_data <= res_c;
      else if (move_s) m_data <= s_data;
      if (load_s)      s_data <= res_c;
    end
  end

  assign out_sum  = m_data[WIDTH-1:0];
  assign out_cout = m_data[WIDTH];
  assign out_ovf  = m_data[WIDTH+1];

endmodule

// File: tb/tb_ling_sum_stage.sv
// Directed bench for ling_sum_stage: an 8-bit instance for the handshake
// and corner cases, a 64-bit instance for streaming random operands.

module tb_ling_sum_stage;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid8, in_ready8, in_cin8, out_valid8, out_ready8;
  logic [7:0] in_p8, in_g8, in_h8, out_sum8;
  logic       out_cout8, out_ovf8;

  logic        in_valid64, in_ready64, in_cin64, out_valid64, out_ready64;
  logic [63:0] in_p64, in_g64, in_h64, out_sum64;
  logic        out_cout64, out_ovf64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ling_sum_stage #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_p(in_p8), .in_g(in_g8), .in_h(in_h8), .in_cin(in_cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_cout(out_cout8), .out_ovf(out_ovf8)
  );

  ling_sum_stage #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_p(in_p64), .in_g(in_g64), .in_h(in_h64), .in_cin(in_cin64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_sum(out_sum64), .out_cout(out_cout64), .out_ovf(out_ovf64)
  );

  // Upstream carry tree: h[1] = g0|cin, h[k] = g[k-1] | t[k-2]&h[k-1];
  // h[k] is placed at bit k-1.
  task automatic ling_vec(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input int n, output logic [63:0] p, output logic [63:0] g,
                          output logic [63:0] h);
    logic [63:0] t;
    p = a ^ b;
    g = a & b;
    t = p | g;
    h = '0;
    h[0] = g[0] | cin;
    for (int k = 1; k < n; k++) h[k] = g[k] | (t[k-1] & h[k-1]);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [63:0] p, g, h;
    ling_vec({56'd0, a}, {56'd0, b}, cin, 8, p, g, h);
    in_valid8 = 1'b1;
    in_p8     = p[7:0];
    in_g8     = g[7:0];
    in_h8     = h[7:0];
    in_cin8   = cin;
  endtask

  // {ovf, cout, sum} for 8-bit checks, hand values passed in directly.
  task automatic chk8(input string name, input logic [9:0] want);
    checks++;
    if ({out_valid8, out_ovf8, out_cout8, out_sum8} !== {1'b1, want}) begin
      errors++;
      $display("FAIL %s got valid=%b ovf=%b cout=%b sum=%h want valid=1 ovf=%b cout=%b sum=%h",
               name, out_valid8, out_ovf8, out_cout8, out_sum8, want[9], want[8], want[7:0]);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    out_ready8  = 1'b1;
    in_valid64  = 1'b0;
    out_ready64 = 1'b1;
    in_p64 = '0; in_g64 = '0; in_h64 = '0; in_cin64 = 1'b0;
    drive8(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid8, out_sum8, out_cout8, out_ovf8, in_ready8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got valid=%b sum=%h cout=%b ovf=%b rdy=%b want 0 00 0 0 1",
               out_valid8, out_sum8, out_cout8, out_ovf8, in_ready8);
    end
    checks++;
    if ({out_valid64, in_ready64, out_sum64} !== {1'b0, 1'b1, 64'd0}) begin
      errors++;
      $display("FAIL reset_state64 got valid=%b rdy=%b sum=%h want 0 1 0", out_valid64, in_ready64, out_sum64);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // 0xFF + 0x01: wraps to zero with carry-out, no signed overflow.
    chk8("first_after_reset", {1'b0, 1'b1, 8'h00});
  endtask

  task automatic test_overflow;
    drive8(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk8("pos_overflow", {1'b1, 1'b0, 8'h80});
    drive8(8'h80, 8'hFF, 1'b0);
    @(negedge clk);
    chk8("neg_overflow", {1'b1, 1'b1, 8'h7F});
    drive8(8'h12, 8'h34, 1'b1);
    @(negedge clk);
    chk8("cin_add", {1'b0, 1'b0, 8'h47});
  endtask

  task automatic test_idle_dontcare;
    in_valid8 = 1'b0;
    in_p8 = 8'hA5; in_g8 = 8'h5A; in_h8 = 8'hFF; in_cin8 = 1'b1;
    @(negedge clk);
    in_p8 = 8'h3C;
    @(negedge clk);
    checks++;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++;
      $display("FAIL idle_inputs got valid=%b rdy=%b want valid=0 rdy=1", out_valid8, in_ready8);
    end
  endtask

  task automatic test_back_pressure;
    out_ready8 = 1'b0;
    drive8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    drive8(8'h80, 8'h80, 1'b1);
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_ready got rdy=%b want 1", in_ready8);
    end
    @(negedge clk);
    drive8(8'h40, 8'h3F, 1'b1);
    checks++;
    if (in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_ready got rdy=%b want 0", in_ready8);
    end
    chk8("bp_head", {1'b0, 1'b0, 8'h30});
    repeat (2) @(negedge clk);
    chk8("bp_hold_stable", {1'b0, 1'b0, 8'h30});
    checks++;
    if (in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL bp_still_full got rdy=%b want 0", in_ready8);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    chk8("bp_drain_second", {1'b1, 1'b1, 8'h01});
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_reopen got rdy=%b want 1", in_ready8);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    chk8("bp_third", {1'b1, 1'b0, 8'h80});
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got valid=%b want 0", out_valid8);
    end
  endtask

  task automatic test_stream64;
    logic [65:0] q[$];
    logic [63:0] a, b, p, g, h;
    logic        cin;
    logic [64:0] full;
    logic [65:0] want;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        want = q.pop_front();
        checks++;
        if ({out_valid64, in_ready64, out_ovf64, out_cout64, out_sum64} !== {2'b11, want}) begin
          errors++;
          $display("FAIL stream64 #%0d got v=%b r=%b ovf=%b cout=%b sum=%h want v=1 r=1 ovf=%b cout=%b sum=%h",
                   i - 1, out_valid64, in_ready64, out_ovf64, out_cout64, out_sum64,
                   want[65], want[64], want[63:0]);
        end
      end
      if (i < 1000) begin
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        cin = 1'($urandom_range(1, 0));
        if (i == 0) begin a = '1; b = 64'd0; cin = 1'b1; end
        if (i == 1) begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; end
        ling_vec(a, b, cin, 64, p, g, h);
        in_valid64 = 1'b1;
        in_p64 = p; in_g64 = g; in_h64 = h; in_cin64 = cin;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        want = {(a[63] == b[63]) && (full[63] != a[63]), full};
        q.push_back(want);
      end else begin
        in_valid64 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid64 !== 1'b0) begin
      errors++;
      $display("FAIL stream64_end got valid=%b want 0", out_valid64);
    end
  endtask

  task automatic test_reset_full;
    out_ready8 = 1'b0;
    drive8(8'h01, 8'h02, 1'b0);
    @(negedge clk);
    drive8(8'h03, 8'h04, 1'b0);
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++;
    if ({out_valid8, in_ready8} !== 2'b10) begin
      errors++;
      $display("FAIL full_before_reset got valid=%b rdy=%b want 1 0", out_valid8, in_ready8);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid8, in_ready8, out_sum8} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got valid=%b rdy=%b sum=%h want 0 1 00", out_valid8, in_ready8, out_sum8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++;
      $display("FAIL entries_lost got valid=%b rdy=%b want 0 1", out_valid8, in_ready8);
    end
  endtask

  initial begin
    test_reset;
    test_overflow;
    test_idle_dontcare;
    test_back_pressure;
    test_stream64;
    test_reset_full;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ling_sum_stage.md
Name: ling_sum_stage

Overview:
- Registered output stage of the Ling adder datapath. Sits directly downstream of the Ling carry-lookahead tree.
- Consumes the bit propagate/generate vectors, the Ling pseudo-carries h[WIDTH:1] and the carry-in.
- Forms the true sum, carry-out and signed overflow, and presents them through a valid/ready interface.
- Includes a 2-entry skid buffer so in_ready is driven from a register, not combinationally from out_ready.

Parameters:
- WIDTH, 64, operand width in bits; legal range ≥ 2.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  upstream presents a valid (p, g, h, cin) set.
- in_ready  output  1  stage accepts input this cycle.
- in_p  input  WIDTH  bit propagate, p[i] = a[i] ^ b[i].
- in_g  input  WIDTH  bit generate, g[i] = a[i] & b[i].
- in_h  input  WIDTH  Ling pseudo-carries; in_h[k-1] carries h[k] for k = 1..WIDTH.
- in_cin  input  1  adder carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  a + b + cin, low WIDTH bits.
- out_cout  output  1  unsigned carry-out.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Arithmetic, combinational on the inputs, captured at input transfer:
  - t[i] = p[i] | g[i].
  - c[0] = cin.
  - c[i] = t[i-1] & h[i] for i = 1..WIDTH-1.
  - sum[i] = p[i] ^ c[i].
  - cout = t[WIDTH-1] & h[WIDTH].
  - ovf = c[WIDTH-1] ^ cout.
  - Computation is unsigned modulo 2^WIDTH; no saturation.
- Storage: main register M (drives out_*) and skid register S, each with its own valid bit.
- State machine (encoded by the valid bits):
  - EMPTY (M invalid):
    - in_ready = 1.
    - Input transfer loads M → ONE.
  - ONE (M valid, S invalid):
    - in_ready = 1.
    - Input and output in the same cycle: M reloads with the new result, stays ONE.
    - Output only → EMPTY.
    - Input only (out_ready = 0): result goes to S → FULL.
  - FULL (both valid):
    - in_ready = 0; inputs ignored.
    - Output transfer: S moves to M, S invalidated → ONE.
- Latency and throughput:
  - Latency: 1 cycle from input transfer to out_valid when in EMPTY/ONE.
  - Throughput: 1 result/cycle while out_ready is held high.
- Ordering: results leave in acceptance order. Nothing is dropped or duplicated.
- Output stability: out_sum/out_cout/out_ovf hold stable while out_valid & !out_ready.
- Reset values:
  - out_valid = 0, S valid = 0, in_ready = 1.
  - out_sum = 0, out_cout = 0, out_ovf = 0.
- Reset mid-operation: buffered results are discarded. In the first cycle after rst_n rises, the stage is EMPTY.
- in_ready is a registered function of the S valid bit only; it has no combinational path from out_ready or in_valid.
- in_* values while in_valid = 0 are don't-care and must not change state.

Test Plan (bench drives p/g from a, b and h from the Ling recurrence h[1] = g0|cin, h[k] = g[k-1] | t[k-2]&h[k-1]; WIDTH = 8 unless noted):
- Reset: hold rst_n = 0 with in_valid = 1 → out_valid = 0, outputs 0, in_ready = 1; after release, first accepted input appears next cycle.
- a = 0xFF, b = 0x01, cin = 0 (p = 0xFE, g = 0x01, h = 0xFF) → sum = 0x00, cout = 1, ovf = 0, 1 cycle after acceptance.
- a = 0x7F, b = 0x01, cin = 0 (p = 0x7E, g = 0x01, h = 0xFF) → sum = 0x80, cout = 0, ovf = 1.
- Back-pressure: out_ready = 0, three consecutive valid inputs → first two accepted (FULL), in_ready = 0 on the third. Raising out_ready drains both in order, then the third is accepted.
- Streaming, WIDTH = 64: 1000 random a/b/cin with out_ready = 1 → one result per cycle, all matching a + b + cin with correct cout/ovf, no bubbles.
- Reset asserted while FULL → both entries lost, out_valid = 0 immediately (asynchronous), in_ready = 1.
